// File: rtl/sha_core_arbiter.sv
// -----------------------------------------------------------------------------
// sha_core_arbiter
//
// Shares one SHA-256 compression core between two requesters. A granted
// requester owns the core for a whole multi-block message: the arbiter pulses
// o_core_start once per 512-bit block (o_core_init on the first block so the
// core loads the IV) and waits for i_core_done after each block. A per-block
// watchdog aborts the message if the core stays silent too long. Arbitration
// between simultaneous requests is round-robin on the last served requester.
//
// Parameters
//   TIMEOUT_CYC  max cycles waited for i_core_done per block before abort
//   TMR_W        watchdog timer width, 2**TMR_W must exceed TIMEOUT_CYC
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous reset, active-high
//   i_req0/1      level request, held until the matching ack/err pulse
//   i_blkcnt0/1   message length in blocks (0 is treated as 1)
//   i_core_done   one-cycle pulse from the core, block compression finished
//   o_ack0/1      one-cycle pulse, message hashed successfully
//   o_err0/1      one-cycle pulse, message aborted on timeout
//   o_core_start  one-cycle pulse, start one block compression
//   o_core_init   high with o_core_start on the first block of a message
//   o_core_sel    core data mux select (owner), stable for the whole message
//   o_busy        high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module sha_core_arbiter #(
  parameter int TIMEOUT_CYC = 1024,
  parameter int TMR_W       = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req0,
  input  logic       i_req1,
  input  logic [7:0] i_blkcnt0,
  input  logic [7:0] i_blkcnt1,
  input  logic       i_core_done,
  output logic       o_ack0,
  output logic       o_ack1,
  output logic       o_err0,
  output logic       o_err1,
  output logic       o_core_start,
  output logic       o_core_init,
  output logic       o_core_sel,
  output logic       o_busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  // Timer value at which the watchdog fires; the timer starts at 0 in the
  // first WAIT cycle, so the abort lands TIMEOUT_CYC cycles after core_start.
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYC - 1);

  state_t           r_state;
  logic             r_owner;
  logic             r_last;
  logic [7:0]       r_remaining;
  logic [TMR_W-1:0] r_timer;

  logic r_ack0, r_ack1, r_err0, r_err1;
  logic r_core_start, r_core_init, r_busy;

  logic             w_any_req;
  logic             w_grant;
  logic [7:0]       w_blk_raw;
  logic [7:0]       w_blk_eff;
  logic [TMR_W-1:0] w_tmr_inc;

  // Round-robin: on contention the requester not served last wins.
  assign w_any_req = i_req0 | i_req1;
  assign w_grant   = (i_req0 && i_req1) ? ~r_last : i_req1;
  assign w_blk_raw = w_grant ? i_blkcnt1 : i_blkcnt0;
  assign w_blk_eff = (w_blk_raw == 8'd0) ? 8'd1 : w_blk_raw;
  assign w_tmr_inc = r_timer + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_last       <= 1'b1;
      r_remaining  <= 8'd0;
      r_timer      <= '0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_err0       <= 1'b0;
      r_err1       <= 1'b0;
      r_core_start <= 1'b0;
      r_core_init  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      // Pulse outputs default low; states below raise them for the cycle
      // in which the FSM sits in the matching state.
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_err0       <= 1'b0;
      r_err1       <= 1'b0;
      r_core_start <= 1'b0;
      r_core_init  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner      <= w_grant;
            r_remaining  <= w_blk_eff;
            r_state      <= S_START;
            r_core_start <= 1'b1;
            r_core_init  <= 1'b1;
            r_busy       <= 1'b1;
          end
        end

        S_START: begin
          r_timer <= '0;
          r_state <= S_WAIT;
        end

        S_WAIT: begin
          r_timer <= w_tmr_inc;
          // Completion is checked before the watchdog so a done arriving on
          // the expiry cycle still counts as success.
          if (i_core_done) begin
            r_remaining <= r_remaining - 8'd1;
            if (r_remaining == 8'd1) begin
              r_state <= S_DONE;
              r_ack0  <= ~r_owner;
              r_ack1  <= r_owner;
            end else begin
              r_state      <= S_START;
              r_core_start <= 1'b1;
            end
          end else if (w_tmr_inc == TMO_LAST) begin
            r_state <= S_ERR;
            r_err0  <= ~r_owner;
            r_err1  <= r_owner;
          end
        end

        S_DONE, S_ERR: begin
          r_last  <= r_owner;
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ack0       = r_ack0;
  assign o_ack1       = r_ack1;
  assign o_err0       = r_err0;
  assign o_err1       = r_err1;
  assign o_core_start = r_core_start;
  assign o_core_init  = r_core_init;
  assign o_core_sel   = r_owner;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_sha_core_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sha_core_arbiter
//
// Bench for sha_core_arbiter. Two instances share the stimulus: dut with the
// default watchdog and dut_t with TIMEOUT_CYC = 16 for the abort scenarios.
// The reference model is message-level: who is granted (round-robin pointer),
// how many blocks a message takes, and the cycle at which each pulse appears.
// -----------------------------------------------------------------------------
module tb_sha_core_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] blk0 = 8'd0, blk1 = 8'd0;
  logic       done = 1'b0;

  logic ack0, ack1, err0, err1, cstart, cinit, csel, busy;
  logic t_ack0, t_ack1, t_err0, t_err1, t_cstart, t_cinit, t_csel, t_busy;

  logic [7:0] obs, t_obs;
  assign obs   = {busy, cstart, cinit, csel, ack0, ack1, err0, err1};
  assign t_obs = {t_busy, t_cstart, t_cinit, t_csel, t_ack0, t_ack1, t_err0, t_err1};

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state: last served requester and currently held owner.
  logic m_last = 1'b1;
  logic m_sel  = 1'b0;

  always #5 clk = ~clk;

  sha_core_arbiter dut (
    .clk(clk), .rst(rst), .i_req0(req0), .i_req1(req1),
    .i_blkcnt0(blk0), .i_blkcnt1(blk1), .i_core_done(done),
    .o_ack0(ack0), .o_ack1(ack1), .o_err0(err0), .o_err1(err1),
    .o_core_start(cstart), .o_core_init(cinit), .o_core_sel(csel), .o_busy(busy)
  );

  sha_core_arbiter #(.TIMEOUT_CYC(16), .TMR_W(5)) dut_t (
    .clk(clk), .rst(rst), .i_req0(req0), .i_req1(req1),
    .i_blkcnt0(blk0), .i_blkcnt1(blk1), .i_core_done(done),
    .o_ack0(t_ack0), .o_ack1(t_ack1), .o_err0(t_err0), .o_err1(t_err1),
    .o_core_start(t_cstart), .o_core_init(t_cinit), .o_core_sel(t_csel), .o_busy(t_busy)
  );

  // Expected output vector in the order {busy,start,init,sel,ack0,ack1,err0,err1}.
  function automatic logic [7:0] ev(input logic b, input logic s, input logic i,
                                    input logic sel, input logic a0, input logic a1,
                                    input logic e0, input logic e1);
    return {b, s, i, sel, a0, a1, e0, e1};
  endfunction

  function automatic int eff_blocks(input logic [7:0] n);
    return (n == 8'd0) ? 1 : int'(n);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    done = 1'b0;
    tick();
    tick();
    rst  = 1'b0;
    m_last = 1'b1;
    m_sel  = 1'b0;
    tick();
  endtask

  // Runs one complete message on dut. Entry: an IDLE cycle with the request
  // inputs already driven. Exit: the IDLE cycle after the ack pulse.
  task automatic serve_msg(input logic owner, input int nblk, input int mind,
                           input int maxd, input bit hold, input bit raise_other);
    logic [7:0] exp;
    int d;
    tick();
    exp = ev(1'b1, 1'b1, 1'b1, owner, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL first_start t=%0t: observed %b required %b", $time, obs, exp);
    end
    if (raise_other) begin
      if (owner) begin req0 = 1'b1; blk0 = 8'($urandom_range(0, 4)); end
      else       begin req1 = 1'b1; blk1 = 8'($urandom_range(0, 4)); end
    end
    for (int b = 0; b < nblk; b++) begin
      d = $urandom_range(mind, maxd);
      done = 1'b0;
      for (int j = 0; j < d; j++) begin
        tick();
        exp = ev(1'b1, 1'b0, 1'b0, owner, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (obs !== exp) begin
          n_fail++;
          $display("FAIL wait_block%0d t=%0t: observed %b required %b", b, $time, obs, exp);
        end
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      if (b < nblk - 1) begin
        exp = ev(1'b1, 1'b1, 1'b0, owner, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (obs !== exp) begin
          n_fail++;
          $display("FAIL next_start%0d t=%0t: observed %b required %b", b + 1, $time, obs, exp);
        end
      end else begin
        exp = ev(1'b1, 1'b0, 1'b0, owner, ~owner, owner, 1'b0, 1'b0);
        n_cmp++;
        if (obs !== exp) begin
          n_fail++;
          $display("FAIL ack t=%0t: observed %b required %b", $time, obs, exp);
        end
      end
    end
    if (!hold) begin
      if (owner) req1 = 1'b0;
      else       req0 = 1'b0;
    end
    tick();
    exp = ev(1'b0, 1'b0, 1'b0, owner, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL idle_after t=%0t: observed %b required %b", $time, obs, exp);
    end
    m_last = owner;
    m_sel  = owner;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    n_cmp++;
    if (obs !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: observed %b required %b", obs, 8'h00);
    end
    n_cmp++;
    if (t_obs !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs_t: observed %b required %b", t_obs, 8'h00);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    req0 = 1'b1;
    blk0 = 8'd1;
    serve_msg(1'b0, 1, 64, 64, 1'b0, 1'b0);
  endtask

  task automatic test_contend();
    do_reset();
    req0 = 1'b1; blk0 = 8'd2;
    req1 = 1'b1; blk1 = 8'd2;
    serve_msg(1'b0, 2, 1, 6, 1'b0, 1'b0);
    serve_msg(1'b1, 2, 1, 6, 1'b0, 1'b0);
  endtask

  task automatic test_zero_blk();
    req1 = 1'b1;
    blk1 = 8'd0;
    serve_msg(1'b1, 1, 1, 6, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    logic [7:0] exp;
    // Done withheld: err0 exactly 16 cycles after the core_start cycle.
    do_reset();
    req0 = 1'b1;
    blk0 = 8'd1;
    tick();
    req0 = 1'b0;
    exp = ev(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (t_obs !== exp) begin
      n_fail++;
      $display("FAIL tmo_start: observed %b required %b", t_obs, exp);
    end
    for (int j = 1; j <= 15; j++) begin
      tick();
      exp = ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (t_obs !== exp) begin
        n_fail++;
        $display("FAIL tmo_wait%0d: observed %b required %b", j, t_obs, exp);
      end
    end
    tick();
    exp = ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (t_obs !== exp) begin
      n_fail++;
      $display("FAIL tmo_err: observed %b required %b", t_obs, exp);
    end
    tick();
    exp = 8'h00;
    n_cmp++;
    if (t_obs !== exp) begin
      n_fail++;
      $display("FAIL tmo_idle: observed %b required %b", t_obs, exp);
    end
    // Done on the expiry cycle: ack wins, no err.
    do_reset();
    req1 = 1'b1;
    blk1 = 8'd1;
    tick();
    req1 = 1'b0;
    for (int j = 1; j <= 15; j++) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    exp = ev(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (t_obs !== exp) begin
      n_fail++;
      $display("FAIL tmo_done_wins: observed %b required %b", t_obs, exp);
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp;
    do_reset();
    req0 = 1'b1;
    blk0 = 8'd3;
    tick();
    req0 = 1'b0;
    tick();
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    exp = ev(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL rstmid_blk2_start: observed %b required %b", obs, exp);
    end
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (obs !== 8'h00) begin
      n_fail++;
      $display("FAIL rstmid_async: observed %b required %b", obs, 8'h00);
    end
    done = 1'b1;
    tick();
    rst = 1'b0;
    m_last = 1'b1;
    m_sel  = 1'b0;
    for (int j = 0; j < 4; j++) begin
      done = j[0];
      tick();
      n_cmp++;
      if (obs !== 8'h00) begin
        n_fail++;
        $display("FAIL rstmid_quiet%0d: observed %b required %b", j, obs, 8'h00);
      end
    end
    done = 1'b0;
    req1 = 1'b1;
    blk1 = 8'd1;
    serve_msg(1'b1, 1, 1, 5, 1'b0, 1'b0);
  endtask

  task automatic test_spurious();
    logic [7:0] exp;
    for (int j = 0; j < 3; j++) begin
      done = 1'b1;
      tick();
      exp = ev(1'b0, 1'b0, 1'b0, m_sel, 1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL spurious_done%0d: observed %b required %b", j, obs, exp);
      end
    end
    done = 1'b0;
    req0 = 1'b1;
    blk0 = 8'd2;
    serve_msg(1'b0, 2, 1, 5, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic owner;
    int   nblk;
    int   p;
    bit   hold, raise;
    do_reset();
    for (int m = 0; m < 40; m++) begin
      if (!req0 && !req1) begin
        p = $urandom_range(1, 3);
        req0 = p[0];
        req1 = p[1];
        blk0 = 8'($urandom_range(0, 4));
        blk1 = 8'($urandom_range(0, 4));
      end
      owner = (req0 && req1) ? ~m_last : req1;
      nblk  = owner ? eff_blocks(blk1) : eff_blocks(blk0);
      hold  = ($urandom_range(0, 3) == 0);
      raise = !(req0 && req1) && ($urandom_range(0, 1) == 1);
      serve_msg(owner, nblk, 1, 8, hold, raise);
      if (hold) begin
        if (owner) blk1 = 8'($urandom_range(0, 4));
        else       blk0 = 8'($urandom_range(0, 4));
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contend();
    test_zero_blk();
    test_timeout();
    test_reset_mid();
    test_spurious();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sha_core_arbiter.md
SHA_CORE_ARBITER -- requirements
Module: sha_core_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1024, max cycles waited for core_done per block before abort.
REQ-002 Parameter TMR_W, default 11, timer width; SHALL satisfy 2^TMR_W > TIMEOUT_CYC.
REQ-003 clk  input  1  system clock, all logic rising-edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req0, req1  input  1 each  hash request from requester 0 / 1, level, held until ackN or errN.
REQ-006 blkcnt0, blkcnt1  input  8 each  number of 512-bit blocks in requester message; 0 treated as 1.
REQ-007 ack0, ack1  output  1 each  one-cycle pulse, message hashed successfully.
REQ-008 err0, err1  output  1 each  one-cycle pulse, message aborted on timeout.
REQ-009 core_start  output  1  one-cycle pulse starting one block compression in the SHA-256 core.
REQ-010 core_init  output  1  high with core_start on first block of a message (core loads IV).
REQ-011 core_done  input  1  one-cycle pulse from core, block compression complete.
REQ-012 core_sel  output  1  owner of core data mux (0 = requester 0, 1 = requester 1), stable for whole message.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 FSM states: IDLE, START, WAIT, DONE, ERR; all outputs Moore-decoded from registered state/owner.
REQ-015 IDLE: if any reqN high at clock edge, latch owner, latch remaining = blkcntN (0 -> 1), go START; else stay.
REQ-016 Arbitration round-robin: both requests high -> grant requester not served last; after reset requester 0 has priority.
REQ-017 Requests sampled only in IDLE; req changes in other states ignored.
REQ-018 START: core_start = 1 for exactly one cycle; core_init = 1 if first block of message; timer cleared; next state WAIT.
REQ-019 WAIT: timer increments each cycle; on core_done, remaining decremented; remaining was 1 -> DONE, else -> START with core_init = 0.
REQ-020 WAIT: timer reaching TIMEOUT_CYC - 1 without core_done -> ERR.
REQ-021 core_done in the same cycle as timeout expiry SHALL count as completion (done wins).
REQ-022 core_done outside WAIT SHALL be ignored (no counter or state change).
REQ-023 DONE: ack[owner] = 1 one cycle, last-served pointer = owner, next IDLE.
REQ-024 ERR: err[owner] = 1 one cycle, last-served pointer = owner, next IDLE; core not restarted.
REQ-025 Latency: req sampled in IDLE at edge k -> core_start high in cycle k+1; final core_done at edge m -> ackN high in cycle m+1.
REQ-026 Per-block spacing: core_done at edge m (non-final) -> next core_start in cycle m+1.
REQ-027 core_sel SHALL not change between entry to START of first block and exit from DONE/ERR.
REQ-028 ack and err never both high; at most one of ack0/ack1/err0/err1 high per cycle.
REQ-029 Requester holding req high after its ack re-enters arbitration, losing to the other requester if both high.

Reset
REQ-030 rst high: state IDLE, pointer = requester 1 last served, timer 0, remaining 0, owner 0; all outputs 0 (core_sel = 0).
REQ-031 rst asserted mid-message aborts immediately without ackN/errN; after release core_start only on a new request.

Verification
REQ-032 req0=1, blkcnt0=1, core_done 64 cycles after core_start -> one core_start with core_init=1, ack0 pulse one cycle after done, busy low next cycle.
REQ-033 req0=req1=1 simultaneously after reset, blkcnt=2 each -> requester 0 served (core_sel=0, 2 core_starts, first core_init=1), ack0, then requester 1 served, ack1.
REQ-034 blkcnt1=0 -> exactly one block issued, ack1 after single core_done.
REQ-035 core_done withheld, TIMEOUT_CYC=16 -> err pulse exactly 16 cycles after core_start cycle, no ack; core_done arriving on cycle 16 -> ack instead.
REQ-036 rst pulsed during WAIT of block 2 of 3 -> outputs 0, no ack/err, next req produces core_init=1.
REQ-037 Spurious core_done in IDLE -> no state change, no ack.
